// File: rtl/common_types_pkg.sv
// Shared types for the memory-side blocks:
// word type, dump engine states and modes.
package common_types_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned STRIDE_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    READ,
    EMIT,
    WAITIN,
    WRITE,
    FIN
  } dump_state_t;

  typedef enum logic {
    DUMP = 1'b0,
    LOAD = 1'b1
  } dump_mode_t;

endpackage

// File: rtl/ram_port_arb.sv
// CPU instruction/data priority mux onto the RAM.
// While locked, only the latched owner port may pass.
module ram_port_arb
  import common_types_pkg::*;
(
  input  logic       pass,
  input  logic       lock,
  input  logic       lock_d,
  input  logic       cpu_iren,
  input  logic       cpu_dren,
  input  logic [3:0] cpu_dwen,
  input  word_t      cpu_iaddr,
  input  word_t      cpu_daddr,
  input  word_t      cpu_dstore,
  input  logic       ram_wait,
  input  word_t      ram_load,
  output logic       cpu_iwait,
  output logic       cpu_dwait,
  output word_t      cpu_iload,
  output word_t      cpu_dload,
  output logic       arb_ren,
  output logic [3:0] arb_wen,
  output word_t      arb_addr,
  output word_t      arb_store,
  output logic       d_win,
  output logic       inflight
);

  logic d_req;
  logic pick_d;
  logic go;

  // Data beats instruction; the locked owner overrides priority.
  always_comb begin
    d_req     = cpu_dren | (|cpu_dwen);
    d_win     = d_req;
    pick_d    = lock ? lock_d : d_req;
    go        = pass & (pick_d ? d_req : cpu_iren);
    inflight  = go & ram_wait;
    cpu_iwait = 1'b1;
    cpu_dwait = 1'b1;
    cpu_iload = '0;
    cpu_dload = '0;
    arb_ren   = 1'b0;
    arb_wen   = 4'h0;
    arb_addr  = '0;
    arb_store = '0;
    if (pass & pick_d) begin
      cpu_dwait = ram_wait;
      cpu_dload = ram_load;
    end
    if (pass & !pick_d) begin
      cpu_iwait = ram_wait;
      cpu_iload = ram_load;
    end
    if (go) begin
      arb_ren   = pick_d ? cpu_dren : cpu_iren;
      arb_wen   = pick_d ? cpu_dwen : 4'h0;
      arb_addr  = pick_d ? cpu_daddr : cpu_iaddr;
      arb_store = pick_d ? cpu_dstore : '0;
    end
  end

endmodule

// File: rtl/ram_dump_ctrl.sv
// RAM dump/load engine between CPU ports and RAM.
// Takes the RAM over on command once the CPU drains.
module ram_dump_ctrl
  import common_types_pkg::*;
#(
  parameter int unsigned LEN_W        = 16,
  parameter int unsigned STRIDE       = STRIDE_DEF,
  parameter bit          SKIP_ZERO_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             cpu_iren,
  input  logic             cpu_dren,
  input  logic [3:0]       cpu_dwen,
  input  word_t            cpu_iaddr,
  input  word_t            cpu_daddr,
  input  word_t            cpu_dstore,
  output logic             cpu_iwait,
  output logic             cpu_dwait,
  output word_t            cpu_iload,
  output word_t            cpu_dload,
  output logic             ram_ren,
  output logic [3:0]       ram_wen,
  output word_t            ram_addr,
  output word_t            ram_store,
  input  word_t            ram_load,
  input  logic             ram_wait,
  input  logic             start,
  input  logic             mode,
  input  word_t            base_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             skip_zero,
  output logic             busy,
  output logic             done,
  output logic             dump_valid,
  input  logic             dump_ready,
  output word_t            dump_addr,
  output word_t            dump_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  word_t            load_data
);

  dump_state_t      state;
  dump_mode_t       mode_r;
  word_t            addr;
  word_t            dreg;
  logic [LEN_W-1:0] cnt;
  logic             skip_r;
  logic             own_d;
  logic             own_v;

  logic             pass;
  logic             lock;
  logic             d_win;
  logic             inflight;
  logic             arb_ren;
  logic [3:0]       arb_wen;
  word_t            arb_addr;
  word_t            arb_store;
  logic             last;
  word_t            addr_nx;

  assign lock    = (state == DRAIN);
  assign pass    = (state == IDLE) | (lock & own_v);
  assign last    = (cnt == LEN_W'(1));
  assign addr_nx = addr + 32'(STRIDE);

  ram_port_arb u_arb (
    .pass       (pass),
    .lock       (lock),
    .lock_d     (own_d),
    .cpu_iren   (cpu_iren),
    .cpu_dren   (cpu_dren),
    .cpu_dwen   (cpu_dwen),
    .cpu_iaddr  (cpu_iaddr),
    .cpu_daddr  (cpu_daddr),
    .cpu_dstore (cpu_dstore),
    .ram_wait   (ram_wait),
    .ram_load   (ram_load),
    .cpu_iwait  (cpu_iwait),
    .cpu_dwait  (cpu_dwait),
    .cpu_iload  (cpu_iload),
    .cpu_dload  (cpu_dload),
    .arb_ren    (arb_ren),
    .arb_wen    (arb_wen),
    .arb_addr   (arb_addr),
    .arb_store  (arb_store),
    .d_win      (d_win),
    .inflight   (inflight)
  );

  // RAM side: engine owns it in READ/WRITE, else arbiter.
  always_comb begin
    ram_ren   = arb_ren;
    ram_wen   = arb_wen;
    ram_addr  = arb_addr;
    ram_store = arb_store;
    unique case (1'b1)
      (state == READ): begin
        ram_ren   = 1'b1;
        ram_wen   = 4'h0;
        ram_addr  = addr;
        ram_store = '0;
      end
      (state == WRITE): begin
        ram_ren   = 1'b0;
        ram_wen   = 4'hF;
        ram_addr  = addr;
        ram_store = dreg;
      end
      default: ;
    endcase
  end

  // Status and stream outputs decoded from state only.
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == FIN);
    dump_valid = (state == EMIT);
    load_ready = (state == WAITIN);
    dump_addr  = addr;
    dump_data  = dreg;
  end

  // Command sequencer: drain CPU, then move words.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      mode_r <= DUMP;
      addr   <= '0;
      dreg   <= '0;
      cnt    <= '0;
      skip_r <= 1'b0;
      own_d  <= 1'b0;
      own_v  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state  <= DRAIN;
          mode_r <= dump_mode_t'(mode);
          addr   <= base_addr;
          cnt    <= len_words;
          skip_r <= skip_zero & SKIP_ZERO_EN;
          own_d  <= d_win;
          own_v  <= d_win | cpu_iren;
        end
        DRAIN: if (!inflight) begin
          own_v <= 1'b0;
          if (cnt == '0)
            state <= FIN;
          else if (mode_r == LOAD)
            state <= WAITIN;
          else
            state <= READ;
        end
        READ: if (!ram_wait) begin
          dreg <= ram_load;
          if (skip_r && ram_load == '0) begin
            addr  <= addr_nx;
            cnt   <= cnt - LEN_W'(1);
            state <= last ? FIN : READ;
          end else begin
            state <= EMIT;
          end
        end
        EMIT: if (dump_ready) begin
          addr  <= addr_nx;
          cnt   <= cnt - LEN_W'(1);
          state <= last ? FIN : READ;
        end
        WAITIN: if (load_valid) begin
          dreg  <= load_data;
          state <= WRITE;
        end
        WRITE: if (!ram_wait) begin
          addr  <= addr_nx;
          cnt   <= cnt - LEN_W'(1);
          state <= last ? FIN : WAITIN;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dump_ctrl.sv
// Bench for ram_dump_ctrl: bench-side RAM,
// expected-beat queue model and directed commands.
module tb_ram_dump_ctrl;
  import common_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        cpu_iren = 1'b0;
  logic        cpu_dren = 1'b0;
  logic [3:0]  cpu_dwen = 4'h0;
  word_t       cpu_iaddr = '0;
  word_t       cpu_daddr = '0;
  word_t       cpu_dstore = '0;
  logic        cpu_iwait;
  logic        cpu_dwait;
  word_t       cpu_iload;
  word_t       cpu_dload;
  logic        ram_ren;
  logic [3:0]  ram_wen;
  word_t       ram_addr;
  word_t       ram_store;
  word_t       ram_load;
  logic        ram_wait = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  word_t       base_addr = '0;
  logic [15:0] len_words = '0;
  logic        skip_zero = 1'b0;
  logic        busy;
  logic        done;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  word_t       dump_addr;
  word_t       dump_data;
  logic        load_valid = 1'b0;
  logic        load_ready;
  word_t       load_data = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] ld_q[$];
  int          ld_idx = 0;
  bit          ld_gap = 1'b0;
  bit          tog_ready = 1'b0;
  bit          chk_istall = 1'b0;
  int          done_cnt = 0;
  int          req_cnt = 0;
  bit          hold = 1'b0;
  logic [31:0] h_a;
  logic [31:0] h_d;

  ram_dump_ctrl dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .cpu_iren   (cpu_iren),
    .cpu_dren   (cpu_dren),
    .cpu_dwen   (cpu_dwen),
    .cpu_iaddr  (cpu_iaddr),
    .cpu_daddr  (cpu_daddr),
    .cpu_dstore (cpu_dstore),
    .cpu_iwait  (cpu_iwait),
    .cpu_dwait  (cpu_dwait),
    .cpu_iload  (cpu_iload),
    .cpu_dload  (cpu_dload),
    .ram_ren    (ram_ren),
    .ram_wen    (ram_wen),
    .ram_addr   (ram_addr),
    .ram_store  (ram_store),
    .ram_load   (ram_load),
    .ram_wait   (ram_wait),
    .start      (start),
    .mode       (mode),
    .base_addr  (base_addr),
    .len_words  (len_words),
    .skip_zero  (skip_zero),
    .busy       (busy),
    .done       (done),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data)
  );

  always #5 CLK = ~CLK;

  assign ram_load = mem[ram_addr[11:2]];

  always @(posedge CLK) begin
    if (nRST && !ram_wait) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b])
          mem[ram_addr[11:2]][8*b +: 8] <= ram_store[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void build_dump(input logic [31:0] b,
                                     input int len, input bit sk);
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < len; i++) begin
      a = b + 32'(i * 4);
      d = mem[a[11:2]];
      if (!(sk && d == 32'h0)) begin
        exp_a.push_back(a);
        exp_d.push_back(d);
      end
    end
  endfunction

  // Compare process: dump beats vs model, hold stability, stalls.
  always @(negedge CLK) begin
    if (!nRST) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("valid_held", {31'd0, dump_valid}, 32'd1);
        if (dump_valid) begin
          chk("hold_addr", dump_addr, h_a);
          chk("hold_data", dump_data, h_d);
        end
      end
      if (dump_valid && dump_ready) begin
        if (exp_a.size() == 0) begin
          chk("extra_beat", dump_addr, 32'hxxxxxxxx);
        end else begin
          chk("beat_addr", dump_addr, exp_a.pop_front());
          chk("beat_data", dump_data, exp_d.pop_front());
        end
      end
      if (dump_valid && load_ready)
        chk("excl", 32'd1, 32'd0);
      hold = dump_valid && !dump_ready;
      h_a  = dump_addr;
      h_d  = dump_data;
      if (done) done_cnt++;
      if (ram_ren || (|ram_wen)) req_cnt++;
      if (chk_istall && busy && cpu_iren) begin
        chk("istall_wait", {31'd0, cpu_iwait}, 32'd1);
        chk("istall_load", cpu_iload, 32'd0);
      end
    end
  end

  task automatic do_start(input bit m, input logic [31:0] b,
                          input int len, input bit sk);
    @(posedge CLK); #1;
    start     = 1'b1;
    mode      = m;
    base_addr = b;
    len_words = 16'(len);
    skip_zero = sk;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    forever begin
      @(negedge CLK);
      n++;
      if (load_valid && load_ready) ld_idx++;
      if (done) break;
      if (n >= lim) begin
        chk("timeout", 32'(n), 32'(lim + 1));
        break;
      end
      @(posedge CLK); #1;
      if (tog_ready) dump_ready = ~dump_ready;
      load_valid = (!ld_gap || (n % 2 == 0)) && (ld_idx < ld_q.size());
      load_data  = (ld_idx < ld_q.size()) ? ld_q[ld_idx] : 32'h0;
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge CLK);
    #1;
  endtask

  int n;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h40] = 32'd1;
    mem[10'h41] = 32'd0;
    mem[10'h42] = 32'd3;
    mem[10'h43] = 32'd4;
    mem[10'hC0] = 32'h12345678;
    mem[10'h3FF] = 32'h11;
    mem[10'h000] = 32'h22;

    // Reset state
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dvalid", {31'd0, dump_valid}, 32'd0);
    chk("rst_lready", {31'd0, load_ready}, 32'd0);
    chk("rst_ren", {31'd0, ram_ren}, 32'd0);
    chk("rst_wen", {28'd0, ram_wen}, 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    @(posedge CLK); #2;
    nRST = 1'b1;

    // IDLE passthrough: instruction alone, then data wins
    @(posedge CLK); #1;
    cpu_iren  = 1'b1;
    cpu_iaddr = 32'h100;
    @(negedge CLK);
    chk("pt_i_ren", {31'd0, ram_ren}, 32'd1);
    chk("pt_i_addr", ram_addr, 32'h100);
    chk("pt_i_load", cpu_iload, 32'd1);
    chk("pt_i_wait", {31'd0, cpu_iwait}, 32'd0);
    chk("pt_i_dwait", {31'd0, cpu_dwait}, 32'd1);
    @(posedge CLK); #1;
    cpu_dren  = 1'b1;
    cpu_daddr = 32'h108;
    @(negedge CLK);
    chk("pt_d_addr", ram_addr, 32'h108);
    chk("pt_d_load", cpu_dload, 32'd3);
    chk("pt_d_iwait", {31'd0, cpu_iwait}, 32'd1);
    chk("pt_d_iload", cpu_iload, 32'd0);
    @(posedge CLK); #1;
    cpu_iren = 1'b0;
    cpu_dren = 1'b0;

    // Dump, no skip, ready held high
    build_dump(32'h100, 4, 1'b0);
    chk("model_n4", 32'(exp_a.size()), 32'd4);
    chk("model_d1", exp_d[1], 32'd0);
    dump_ready = 1'b1;
    done_cnt = 0;
    do_start(1'b0, 32'h100, 4, 1'b0);
    wait_done(200, n);
    chk("dump_cycles", 32'(n), 32'd10);
    settle();
    chk("dump_left", 32'(exp_a.size()), 32'd0);
    chk("dump_done1", 32'(done_cnt), 32'd1);

    // Dump with zero skip, ready toggling
    build_dump(32'h100, 4, 1'b1);
    chk("model_skip_n", 32'(exp_a.size()), 32'd3);
    chk("model_skip_a1", exp_a[1], 32'h108);
    tog_ready = 1'b1;
    done_cnt = 0;
    do_start(1'b0, 32'h100, 4, 1'b1);
    wait_done(200, n);
    tog_ready = 1'b0;
    dump_ready = 1'b1;
    settle();
    chk("skip_left", 32'(exp_a.size()), 32'd0);
    chk("skip_done1", 32'(done_cnt), 32'd1);

    // Gapped load of three words
    ld_q = '{32'hA5A5A5A5, 32'h0, 32'hDEADBEEF};
    ld_idx = 0;
    ld_gap = 1'b1;
    mem[10'h80] = 32'h5555AAAA;
    mem[10'h81] = 32'h77777777;
    done_cnt = 0;
    do_start(1'b1, 32'h200, 3, 1'b0);
    wait_done(200, n);
    settle();
    chk("load_w0", mem[10'h80], 32'hA5A5A5A5);
    chk("load_w1", mem[10'h81], 32'h0);
    chk("load_w2", mem[10'h82], 32'hDEADBEEF);
    chk("load_w3", mem[10'h83], 32'h0);
    chk("load_cnt", 32'(dut.cnt), 32'd0);
    chk("load_done1", 32'(done_cnt), 32'd1);
    ld_q.delete();
    ld_idx = 0;
    load_valid = 1'b0;

    // Zero-length command
    req_cnt = 0;
    do_start(1'b0, 32'h100, 0, 1'b0);
    wait_done(50, n);
    chk("len0_cycles", 32'(n), 32'd2);
    settle();
    chk("len0_reqs", 32'(req_cnt), 32'd0);

    // CPU read in flight with ram_wait high while start arrives
    build_dump(32'h100, 1, 1'b0);
    done_cnt = 0;
    @(posedge CLK); #1;
    cpu_dren  = 1'b1;
    cpu_daddr = 32'h300;
    cpu_iren  = 1'b1;
    cpu_iaddr = 32'h100;
    ram_wait  = 1'b1;
    start     = 1'b1;
    mode      = 1'b0;
    base_addr = 32'h100;
    len_words = 16'd1;
    skip_zero = 1'b0;
    @(negedge CLK);
    chk("dr_idle_addr", ram_addr, 32'h300);
    @(posedge CLK); #1;
    start = 1'b0;
    chk_istall = 1'b1;
    @(negedge CLK);
    chk("dr_busy", {31'd0, busy}, 32'd1);
    chk("dr_ren", {31'd0, ram_ren}, 32'd1);
    chk("dr_addr", ram_addr, 32'h300);
    chk("dr_dwait", {31'd0, cpu_dwait}, 32'd1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    ram_wait = 1'b0;
    @(negedge CLK);
    chk("dr_dwait0", {31'd0, cpu_dwait}, 32'd0);
    chk("dr_dload", cpu_dload, 32'h12345678);
    chk("dr_novalid", {31'd0, dump_valid}, 32'd0);
    @(posedge CLK); #1;
    cpu_dren = 1'b0;
    wait_done(100, n);
    chk_istall = 1'b0;
    @(posedge CLK); #1;
    cpu_iren = 1'b0;
    settle();
    chk("dr_left", 32'(exp_a.size()), 32'd0);
    chk("dr_done1", 32'(done_cnt), 32'd1);

    // Reset in EMIT aborts; then wrap-around dump
    build_dump(32'h100, 4, 1'b0);
    dump_ready = 1'b0;
    do_start(1'b0, 32'h100, 4, 1'b0);
    n = 0;
    while (!dump_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("emit_reached", {31'd0, dump_valid}, 32'd1);
    @(posedge CLK); #2;
    nRST = 1'b0;
    #1;
    chk("ab_dvalid", {31'd0, dump_valid}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_ren", {31'd0, ram_ren}, 32'd0);
    chk("ab_addr", dump_addr, 32'd0);
    exp_a.delete();
    exp_d.delete();
    @(posedge CLK); #2;
    nRST = 1'b1;
    dump_ready = 1'b1;
    build_dump(32'hFFFFFFFC, 2, 1'b0);
    chk("model_wrap_a", exp_a[1], 32'h0);
    chk("model_wrap_d", exp_d[0], 32'h11);
    done_cnt = 0;
    do_start(1'b0, 32'hFFFFFFFC, 2, 1'b0);
    wait_done(100, n);
    settle();
    chk("wrap_left", 32'(exp_a.size()), 32'd0);
    chk("wrap_done1", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
